// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file : 32 x XLEN integer register file (x0..x31) for the RV32I core.
//
// - Two independent combinational read ports (rs1, rs2).
// - One synchronous write port qualified by RegWrite.
// - x0 has no storage and always reads as zero.
// - The array is cleared asynchronously while rst_n is low.
//
// Build option:
//   RF_BYPASS_EN : when defined, a read of the address being written in the
//                  same cycle returns rd_write_data (write-through
//                  forwarding). When undefined, reads always return the
//                  stored value.
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_write_data,
    input  logic              RegWrite,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [XLEN-1:0]   ZERO_DATA = {XLEN{1'b0}};

    // Storage exists only for x1..x(NREGS-1); x0 is synthesised as a constant.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    // Write port qualification: an enabled write to a nonzero index.
    logic            wr_en_s;
    logic [XLEN-1:0] rs1_stored_s;
    logic [XLEN-1:0] rs2_stored_s;

    // Qualify the write port; writes to x0 are dropped here.
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWrite && (rd_addr != ZERO_ADDR)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state of the array: only the addressed entry takes the write data.
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en_s && (rd_addr == ADDR_W'(i))) begin
                regs_d[i] = rd_write_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register array: asynchronous clear, otherwise load next-state each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes for the stored values; index 0 falls through to zero.
    always_comb begin
        rs1_stored_s = ZERO_DATA;
        rs2_stored_s = ZERO_DATA;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1_addr == ADDR_W'(i)) begin
                rs1_stored_s = regs_q[i];
            end else begin
                rs1_stored_s = rs1_stored_s;
            end
            if (rs2_addr == ADDR_W'(i)) begin
                rs2_stored_s = regs_q[i];
            end else begin
                rs2_stored_s = rs2_stored_s;
            end
        end
    end

`ifdef RF_BYPASS_EN
    // Read ports with write-through forwarding; x0 still reads zero because
    // wr_en_s is never set for index 0.
    always_comb begin
        rs1_data = rs1_stored_s;
        rs2_data = rs2_stored_s;
        if (rst_n && wr_en_s && (rs1_addr == rd_addr)) begin
            rs1_data = rd_write_data;
        end else begin
            rs1_data = rs1_stored_s;
        end
        if (rst_n && wr_en_s && (rs2_addr == rd_addr)) begin
            rs2_data = rd_write_data;
        end else begin
            rs2_data = rs2_stored_s;
        end
    end
`else
    // Read ports return the stored value; a same-cycle write shows up only
    // after the clock edge.
    always_comb begin
        rs1_data = rs1_stored_s;
        rs2_data = rs2_stored_s;
    end
`endif

endmodule
